// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source end of a req/ack CDC, four-phase by default, two-phase toggle when CDC_HANDSHAKE_TX_TWO_PHASE_EN is defined
module cdc_handshake_tx #(
    parameter int W_DATA = 8,
    parameter int N_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_req,
    output logic [W_DATA-1:0] o_data,
    input  logic              i_ack
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
`ifndef CDC_HANDSHAKE_TX_TWO_PHASE_EN
    localparam logic [1:0] S_REL  = 2'd2;
`endif
    (* keep = "true" *) logic [N_SYNC-1:0] r_ack_sync;
    logic [1:0]        r_state;
    logic              r_req;
    logic [W_DATA-1:0] r_data;
    logic              w_ack;
    logic              w_accept;
    assign w_ack    = r_ack_sync[N_SYNC-1];
    assign i_ready  = (r_state == S_IDLE);
    assign w_accept = i_valid && i_ready;
    assign o_req    = r_req;
    assign o_data   = r_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ack_sync <= '0;
        else
            r_ack_sync <= {r_ack_sync[N_SYNC-2:0], i_ack};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= S_REQ;
            r_data  <= i_data;
`ifdef CDC_HANDSHAKE_TX_TWO_PHASE_EN
            r_req   <= ~r_req;
        end else if (r_state != S_IDLE && w_ack == r_req) begin
            r_state <= S_IDLE;
        end
`else
            r_req   <= 1'b1;
        end else if (r_state == S_REQ && w_ack) begin
            r_state <= S_REL;
            r_req   <= 1'b0;
        end else if (r_state != S_REQ && !w_ack) begin
            // also recovers any undefined state encoding back to IDLE
            r_state <= S_IDLE;
        end
`endif
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed checks of the four-phase handshake with loopback and manual ack
module tb_cdc_handshake_tx;
    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] i_data;
    logic       o_req;
    logic [7:0] o_data;
    logic       i_ack;
    logic       loop;
    logic       ack_m;
    int         n_chk;
    int         n_pass;

    assign i_ack = loop ? o_req : ack_m;

    cdc_handshake_tx #(.W_DATA(8), .N_SYNC(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_req   (o_req),
        .o_data  (o_data),
        .i_ack   (i_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        i_valid = 1'b1;
        i_data = 8'h77;
        loop = 1'b1;
        ack_m = 1'b0;
        tick(2);
        chk("rst_req", o_req, 1'b0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_ready", i_ready, 1'b1);
        // single transfer, loopback; edge A is the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        i_data = 8'hA5;
        tick(1);
        chk("a_req", o_req, 1'b1);
        chk("a_data", o_data, 8'hA5);
        chk("a_ready", i_ready, 1'b0);
        i_valid = 1'b0;
        i_data = 8'hFF;
        tick(2);
        chk("a2_req", o_req, 1'b1);
        chk("a2_data", o_data, 8'hA5);
        tick(1);
        chk("a3_req", o_req, 1'b0);
        chk("a3_ready", i_ready, 1'b0);
        chk("a3_data", o_data, 8'hA5);
        tick(2);
        chk("a5_ready", i_ready, 1'b0);
        tick(1);
        chk("a6_ready", i_ready, 1'b1);
        chk("a6_data", o_data, 8'hA5);
        // back-to-back with valid held high
        i_valid = 1'b1;
        i_data = 8'h01;
        tick(1);
        for (int k = 1; k <= 3; k++) begin
            chk("b2b_acc_data", o_data, k);
            chk("b2b_acc_req", o_req, 1'b1);
            i_data = 8'(k + 1);
            tick(2);
            chk("b2b_hold_req", o_req, 1'b1);
            chk("b2b_hold_data", o_data, k);
            tick(3);
            chk("b2b_busy", i_ready, 1'b0);
            chk("b2b_rel_data", o_data, k);
            tick(1);
            chk("b2b_idle", i_ready, 1'b1);
            if (k == 3) i_valid = 1'b0;
            tick(1);
        end
        chk("b2b_end_req", o_req, 1'b0);
        chk("b2b_end_data", o_data, 8'h03);
        chk("b2b_end_ready", i_ready, 1'b1);
        // slow responder with manual ack
        loop = 1'b0;
        i_valid = 1'b1;
        i_data = 8'h5A;
        tick(1);
        i_valid = 1'b0;
        i_data = 8'hC3;
        tick(20);
        chk("slow_req", o_req, 1'b1);
        chk("slow_ready", i_ready, 1'b0);
        chk("slow_data", o_data, 8'h5A);
        ack_m = 1'b1;
        tick(2);
        chk("slow_sync_req", o_req, 1'b1);
        tick(1);
        chk("slow_rel_req", o_req, 1'b0);
        ack_m = 1'b0;
        tick(2);
        chk("slow_rel_ready", i_ready, 1'b0);
        tick(1);
        chk("slow_idle", i_ready, 1'b1);
        chk("slow_end_data", o_data, 8'h5A);
        // spurious ack pulse while idle
        ack_m = 1'b1;
        tick(1);
        ack_m = 1'b0;
        tick(4);
        chk("spur_req", o_req, 1'b0);
        chk("spur_ready", i_ready, 1'b1);
        // ack already high at accept
        ack_m = 1'b1;
        i_valid = 1'b1;
        i_data = 8'hE7;
        tick(1);
        i_valid = 1'b0;
        chk("early_data", o_data, 8'hE7);
        tick(1);
        chk("early_req", o_req, 1'b1);
        tick(1);
        chk("early_rel", o_req, 1'b0);
        ack_m = 1'b0;
        tick(2);
        chk("early_busy", i_ready, 1'b0);
        tick(1);
        chk("early_idle", i_ready, 1'b1);
        // reset mid-transfer
        loop = 1'b1;
        i_valid = 1'b1;
        i_data = 8'h99;
        tick(1);
        i_valid = 1'b0;
        tick(1);
        chk("mid_inreq", o_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", o_req, 1'b0);
        chk("mid_rst_data", o_data, 8'h00);
        chk("mid_rst_ready", i_ready, 1'b1);
        tick(2);
        rst_n = 1'b1;
        i_valid = 1'b1;
        i_data = 8'h3C;
        tick(1);
        i_valid = 1'b0;
        chk("post_data", o_data, 8'h3C);
        chk("post_req", o_req, 1'b1);
        tick(3);
        chk("post_rel", o_req, 1'b0);
        tick(3);
        chk("post_idle", i_ready, 1'b1);
        chk("post_end_data", o_data, 8'h3C);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
